// File: rtl/seq_monitor_if.sv
// Observation bus between the sequence counter under test and seq_monitor.
// Optional error-history signals exist only when SEQMON_HIST_EN is defined.
interface seq_monitor_if #(
  parameter int CNT_W = 8,
  parameter int ERR_W = 4
);
  logic [2:0]       q_in;
  logic             valid;
  logic [7:0]       label_bcd;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_count;
  logic [CNT_W-1:0] cycle_count;
`ifdef SEQMON_HIST_EN
  logic [2:0]       err_got;
  logic [2:0]       err_exp;

  modport master (
    output q_in, valid,
    input  label_bcd, locked, err, err_count, cycle_count, err_got, err_exp
  );
  modport slave (
    input  q_in, valid,
    output label_bcd, locked, err, err_count, cycle_count, err_got, err_exp
  );
`else
  modport master (
    output q_in, valid,
    input  label_bcd, locked, err, err_count, cycle_count
  );
  modport slave (
    input  q_in, valid,
    output label_bcd, locked, err, err_count, cycle_count
  );
`endif
endinterface

// File: rtl/seq_monitor.sv
// seq_monitor: checks the 001->111->000->010->011->001 counter sequence,
// labels each sample in BCD and reports lock, errors and completed cycles.
// Optional macro SEQMON_HIST_EN adds err_got/err_exp error-history capture.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_SEARCH | no trusted previous sample; next legal sample seeds prev
// S_SYNC   | counting consecutive correct transitions toward LOCK_LEN
// S_LOCKED | sequence tracked; 011->001 wraps increment cycle_count
module seq_monitor #(
  parameter int CNT_W    = 8,
  parameter int ERR_W    = 4,
  parameter int LOCK_LEN = 2
) (
  input  logic        clk,
  input  logic        rst,
  seq_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_SYNC   = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  localparam logic [2:0] LOCK_TGT = 3'(LOCK_LEN);

  state_t           state_q, state_d;
  logic [2:0]       prev_q, prev_d;
  logic [2:0]       match_q, match_d;
  logic [7:0]       label_q, label_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
`ifdef SEQMON_HIST_EN
  logic [2:0]       got_q, got_d;
  logic [2:0]       exp_q, exp_d;
`endif

  logic [2:0]       sample;
  logic             legal;
  logic             correct;
  logic [2:0]       expected;
  logic [ERR_W-1:0] err_cnt_inc;

  function automatic logic [2:0] succ(input logic [2:0] code);
    case (code)
      3'b001:  succ = 3'b111;
      3'b111:  succ = 3'b000;
      3'b000:  succ = 3'b010;
      3'b010:  succ = 3'b011;
      3'b011:  succ = 3'b001;
      default: succ = 3'b000;
    endcase
  endfunction

  function automatic logic [7:0] bcd_label(input logic [2:0] code);
    case (code)
      3'b001:  bcd_label = 8'h01;
      3'b111:  bcd_label = 8'h07;
      3'b000:  bcd_label = 8'h08;
      3'b010:  bcd_label = 8'h10;
      3'b011:  bcd_label = 8'h11;
      default: bcd_label = 8'hFF;
    endcase
  endfunction

  // Next-state and next-output computation for one sample.
  always_comb begin
    sample      = mon.q_in;
    legal       = (bcd_label(sample) != 8'hFF);
    expected    = succ(prev_q);
    correct     = (sample == expected);
    err_cnt_inc = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + ERR_W'(1);

    state_d   = state_q;
    prev_d    = prev_q;
    match_d   = match_q;
    label_d   = label_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    cyc_d     = cyc_q;
`ifdef SEQMON_HIST_EN
    got_d     = got_q;
    exp_d     = exp_q;
`endif

    if (mon.valid) begin
      if (!legal) begin
        err_d     = 1'b1;
        err_cnt_d = err_cnt_inc;
        label_d   = 8'hFF;
        state_d   = S_SEARCH;
        match_d   = 3'd0;
`ifdef SEQMON_HIST_EN
        got_d     = sample;
        exp_d     = 3'b000;
`endif
      end else begin
        label_d = bcd_label(sample);
        prev_d  = sample;
        case (state_q)
          S_SEARCH: begin
            state_d = S_SYNC;
            match_d = 3'd0;
          end
          S_SYNC, S_LOCKED: begin
            if (correct) begin
              if (state_q == S_SYNC) begin
                match_d = match_q + 3'd1;
                if (match_q + 3'd1 == LOCK_TGT) state_d = S_LOCKED;
              end else if (prev_q == 3'b011 && sample == 3'b001) begin
                cyc_d = cyc_q + CNT_W'(1);
              end
            end else begin
              // A repeated value fails the successor test too: stuck counter.
              err_d     = 1'b1;
              err_cnt_d = err_cnt_inc;
              match_d   = 3'd0;
              state_d   = S_SYNC;
`ifdef SEQMON_HIST_EN
              got_d     = sample;
              exp_d     = expected;
`endif
            end
          end
          default: begin
            state_d = S_SEARCH;
            match_d = 3'd0;
          end
        endcase
      end
    end

    locked_d = (state_d == S_LOCKED);
  end

  // State and registered outputs, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_SEARCH;
      prev_q    <= 3'b000;
      match_q   <= 3'd0;
      label_q   <= 8'h00;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      cyc_q     <= '0;
`ifdef SEQMON_HIST_EN
      got_q     <= 3'b000;
      exp_q     <= 3'b000;
`endif
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      match_q   <= match_d;
      label_q   <= label_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      cyc_q     <= cyc_d;
`ifdef SEQMON_HIST_EN
      got_q     <= got_d;
      exp_q     <= exp_d;
`endif
    end
  end

  assign mon.label_bcd   = label_q;
  assign mon.locked      = locked_q;
  assign mon.err         = err_q;
  assign mon.err_count   = err_cnt_q;
  assign mon.cycle_count = cyc_q;
`ifdef SEQMON_HIST_EN
  assign mon.err_got     = got_q;
  assign mon.err_exp     = exp_q;
`endif

endmodule

// File: tb/tb_seq_monitor.sv
// Self-checking bench for seq_monitor: directed scenarios plus a random run,
// compared against a sequence-position reference model.
module tb_seq_monitor;

  localparam int CNT_W    = 8;
  localparam int ERR_W    = 4;
  localparam int LOCK_LEN = 2;
  localparam int ERR_MAX  = (1 << ERR_W) - 1;

  logic clk;
  logic rst;

  seq_monitor_if #(.CNT_W(CNT_W), .ERR_W(ERR_W)) bus ();

  seq_monitor #(.CNT_W(CNT_W), .ERR_W(ERR_W), .LOCK_LEN(LOCK_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .mon (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: legal sequence as a ring, labels as decimal numbers.
  logic [2:0] ring [5] = '{3'b001, 3'b111, 3'b000, 3'b010, 3'b011};
  int         dec  [5] = '{1, 7, 8, 10, 11};

  bit         m_has_prev;
  logic [2:0] m_prev;
  int         m_streak;
  bit         m_locked;
  bit         m_err;
  int         m_errcnt;
  int         m_cyc;
  logic [7:0] m_label;
  logic [2:0] m_got;
  logic [2:0] m_exp;

  function automatic int pos_of(input logic [2:0] c);
    for (int i = 0; i < 5; i++) if (ring[i] == c) return i;
    return -1;
  endfunction

  function automatic logic [2:0] next_of(input logic [2:0] c);
    return ring[(pos_of(c) + 1) % 5];
  endfunction

  function automatic void model_reset();
    m_has_prev = 0; m_prev = 3'b000; m_streak = 0; m_locked = 0;
    m_err = 0; m_errcnt = 0; m_cyc = 0; m_label = 8'h00;
    m_got = 3'b000; m_exp = 3'b000;
  endfunction

  function automatic void model_error();
    m_err = 1;
    if (m_errcnt < ERR_MAX) m_errcnt++;
  endfunction

  function automatic void model_sample(input logic [2:0] s);
    int p;
    p = pos_of(s);
    m_err = 0;
    if (p < 0) begin
      model_error();
      m_label = 8'hFF; m_has_prev = 0; m_streak = 0; m_locked = 0;
      m_got = s; m_exp = 3'b000;
      return;
    end
    m_label = 8'((dec[p] / 10) * 16 + (dec[p] % 10));
    if (!m_has_prev) begin
      m_has_prev = 1; m_streak = 0;
    end else if (s == next_of(m_prev)) begin
      if (m_locked) begin
        if (m_prev == 3'b011 && s == 3'b001) m_cyc = (m_cyc + 1) % (1 << CNT_W);
      end else begin
        m_streak++;
        if (m_streak >= LOCK_LEN) m_locked = 1;
      end
    end else begin
      model_error();
      m_streak = 0; m_locked = 0;
      m_got = s; m_exp = next_of(m_prev);
    end
    m_prev = s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.valid = 1'b0; bus.q_in = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Apply one cycle of input and advance the model; outputs are sampled after.
  task automatic drive(input logic [2:0] q, input bit v);
    @(negedge clk);
    bus.q_in = q; bus.valid = v;
    @(posedge clk);
    #1;
    if (v) model_sample(q);
    else   m_err = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.valid = 1'b0; bus.q_in = 3'b000;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.label_bcd !== 8'h00 || bus.locked !== 1'b0 || bus.err !== 1'b0 ||
        bus.err_count !== 4'd0 || bus.cycle_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_values got label=%h locked=%b err=%b ec=%0d cc=%0d exp all zero",
               bus.label_bcd, bus.locked, bus.err, bus.err_count, bus.cycle_count);
    end
`ifdef SEQMON_HIST_EN
    checks++;
    if (bus.err_got !== 3'b000 || bus.err_exp !== 3'b000) begin
      errors++;
      $display("FAIL reset_hist got %b/%b exp 000/000", bus.err_got, bus.err_exp);
    end
`endif
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_sequence();
    logic [2:0] codes [6] = '{3'b001, 3'b111, 3'b000, 3'b010, 3'b011, 3'b001};
    logic [7:0] labels[6] = '{8'h01, 8'h07, 8'h08, 8'h10, 8'h11, 8'h01};
    bit         lk    [6] = '{0, 0, 1, 1, 1, 1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(codes[i], 1);
      checks++;
      if (bus.label_bcd !== labels[i] || bus.locked !== lk[i] || bus.err !== 1'b0) begin
        errors++;
        $display("FAIL seq_step%0d got label=%h locked=%b err=%b exp label=%h locked=%b err=0",
                 i, bus.label_bcd, bus.locked, bus.err, labels[i], lk[i]);
      end
    end
    checks++;
    if (bus.cycle_count !== 8'd1) begin
      errors++;
      $display("FAIL seq_cycle_count got %0d exp 1", bus.cycle_count);
    end
  endtask

  task automatic test_illegal_code();
    // Continues from locked state with prev=001.
    drive(3'b101, 1);
    checks++;
    if (bus.err !== 1'b1 || bus.err_count !== 4'd1 || bus.label_bcd !== 8'hFF ||
        bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL illegal_hit got err=%b ec=%0d label=%h locked=%b exp 1/1/ff/0",
               bus.err, bus.err_count, bus.label_bcd, bus.locked);
    end
`ifdef SEQMON_HIST_EN
    checks++;
    if (bus.err_got !== 3'b101 || bus.err_exp !== 3'b000) begin
      errors++;
      $display("FAIL illegal_hist got %b/%b exp 101/000", bus.err_got, bus.err_exp);
    end
`endif
    drive(3'b001, 1);
    checks++;
    if (bus.err !== 1'b0 || bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL illegal_pulse_end got err=%b locked=%b exp 0/0", bus.err, bus.locked);
    end
    drive(3'b111, 1);
    drive(3'b000, 1);
    checks++;
    if (bus.locked !== 1'b1 || bus.err_count !== 4'd1) begin
      errors++;
      $display("FAIL illegal_relock got locked=%b ec=%0d exp 1/1", bus.locked, bus.err_count);
    end
  endtask

  task automatic test_skip();
    do_reset();
    drive(3'b001, 1); drive(3'b111, 1); drive(3'b000, 1);
    drive(3'b010, 1); drive(3'b011, 1); drive(3'b001, 1);
    drive(3'b000, 1);
    checks++;
    if (bus.err !== 1'b1 || bus.locked !== 1'b0 || bus.err_count !== 4'd1 ||
        bus.label_bcd !== 8'h08) begin
      errors++;
      $display("FAIL skip_detect got err=%b locked=%b ec=%0d label=%h exp 1/0/1/08",
               bus.err, bus.locked, bus.err_count, bus.label_bcd);
    end
`ifdef SEQMON_HIST_EN
    checks++;
    if (bus.err_got !== 3'b000 || bus.err_exp !== 3'b111) begin
      errors++;
      $display("FAIL skip_hist got %b/%b exp 000/111", bus.err_got, bus.err_exp);
    end
`endif
    drive(3'b010, 1);
    checks++;
    if (bus.locked !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL skip_sync got locked=%b err=%b exp 0/0", bus.locked, bus.err);
    end
    drive(3'b011, 1);
    checks++;
    if (bus.locked !== 1'b1 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL skip_relock got locked=%b err=%b exp 1/0", bus.locked, bus.err);
    end
    // Stuck counter: repeating 011 is a wrong transition.
    drive(3'b011, 1);
    checks++;
    if (bus.err !== 1'b1 || bus.locked !== 1'b0 || bus.err_count !== 4'd2) begin
      errors++;
      $display("FAIL stuck_detect got err=%b locked=%b ec=%0d exp 1/0/2",
               bus.err, bus.locked, bus.err_count);
    end
    // Correct 011->001 in SYNC must not count a cycle.
    drive(3'b001, 1);
    checks++;
    if (bus.cycle_count !== 8'd1 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL sync_wrap_nocount got cc=%0d err=%b exp 1/0", bus.cycle_count, bus.err);
    end
  endtask

  task automatic test_valid_gap();
    do_reset();
    drive(3'b001, 1); drive(3'b111, 1); drive(3'b000, 1); drive(3'b010, 1);
    for (int i = 0; i < 5; i++) begin
      drive(3'($urandom_range(7)), 0);
      checks++;
      if (bus.label_bcd !== 8'h10 || bus.locked !== 1'b1 || bus.err !== 1'b0 ||
          bus.err_count !== 4'd0 || bus.cycle_count !== 8'd0) begin
        errors++;
        $display("FAIL gap_hold%0d got label=%h locked=%b err=%b ec=%0d cc=%0d exp 10/1/0/0/0",
                 i, bus.label_bcd, bus.locked, bus.err, bus.err_count, bus.cycle_count);
      end
    end
    drive(3'b011, 1);
    checks++;
    if (bus.err !== 1'b0 || bus.locked !== 1'b1 || bus.label_bcd !== 8'h11) begin
      errors++;
      $display("FAIL gap_resume got err=%b locked=%b label=%h exp 0/1/11",
               bus.err, bus.locked, bus.label_bcd);
    end
  endtask

  task automatic test_saturation();
    int pulses;
    int lock_seen;
    pulses = 0; lock_seen = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(3'b110, 1);
      if (bus.err === 1'b1) pulses++;
      if (bus.locked !== 1'b0) lock_seen++;
    end
    checks++;
    if (pulses != 20 || lock_seen != 0) begin
      errors++;
      $display("FAIL sat_pulses got pulses=%0d locked_cycles=%0d exp 20/0", pulses, lock_seen);
    end
    checks++;
    if (bus.err_count !== 4'(ERR_MAX)) begin
      errors++;
      $display("FAIL sat_count got %0d exp %0d", bus.err_count, ERR_MAX);
    end
    drive(3'b000, 0);
    checks++;
    if (bus.err !== 1'b0 || bus.err_count !== 4'(ERR_MAX)) begin
      errors++;
      $display("FAIL sat_hold got err=%b ec=%0d exp 0/%0d", bus.err, bus.err_count, ERR_MAX);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(3'b001, 1);
    for (int c = 0; c < 3; c++) begin
      drive(3'b111, 1); drive(3'b000, 1); drive(3'b010, 1);
      drive(3'b011, 1); drive(3'b001, 1);
    end
    checks++;
    if (bus.cycle_count !== 8'd3 || bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL areset_setup got cc=%0d locked=%b exp 3/1", bus.cycle_count, bus.locked);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.label_bcd !== 8'h00 || bus.locked !== 1'b0 || bus.err !== 1'b0 ||
        bus.err_count !== 4'd0 || bus.cycle_count !== 8'd0) begin
      errors++;
      $display("FAIL areset_immediate got label=%h locked=%b err=%b ec=%0d cc=%0d exp zeros",
               bus.label_bcd, bus.locked, bus.err, bus.err_count, bus.cycle_count);
    end
    #1 rst = 1'b0;
    model_reset();
    drive(3'b111, 1);
    checks++;
    if (bus.label_bcd !== 8'h07 || bus.locked !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL areset_search got label=%h locked=%b err=%b exp 07/0/0",
               bus.label_bcd, bus.locked, bus.err);
    end
    drive(3'b000, 1); drive(3'b010, 1);
    checks++;
    if (bus.locked !== 1'b1 || bus.cycle_count !== 8'd0) begin
      errors++;
      $display("FAIL areset_relock got locked=%b cc=%0d exp 1/0", bus.locked, bus.cycle_count);
    end
  endtask

  task automatic test_random();
    logic [2:0] q;
    bit         v;
    int         r;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(99));
      v = (r >= 8);
      if (r < 75 && m_has_prev) q = next_of(m_prev);
      else                      q = 3'($urandom_range(7));
      drive(q, v);
      checks++;
      if (bus.label_bcd !== m_label || bus.locked !== m_locked || bus.err !== m_err ||
          bus.err_count !== 4'(m_errcnt) || bus.cycle_count !== 8'(m_cyc)) begin
        errors++;
        $display("FAIL rand%0d got label=%h locked=%b err=%b ec=%0d cc=%0d exp %h/%b/%b/%0d/%0d",
                 i, bus.label_bcd, bus.locked, bus.err, bus.err_count, bus.cycle_count,
                 m_label, m_locked, m_err, m_errcnt, m_cyc);
      end
`ifdef SEQMON_HIST_EN
      checks++;
      if (bus.err_got !== m_got || bus.err_exp !== m_exp) begin
        errors++;
        $display("FAIL rand_hist%0d got %b/%b exp %b/%b", i, bus.err_got, bus.err_exp,
                 m_got, m_exp);
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.q_in = 3'b000;
    bus.valid = 1'b0;
    test_reset();
    test_sequence();
    test_illegal_code();
    test_skip();
    test_valid_gap();
    test_saturation();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
